// File: rtl/reg_file_pkg.sv
// Shared constants, types and write-priority helper for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_PC_LIMIT = 60;
  localparam int DEF_PC_RESET = 0;

  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B
  } wsel_e;

  // Port A (ALU) always beats port B (load) when both hit the same register.
  function automatic wsel_e write_sel(input logic a_hit, input logic b_hit);
    if (a_hit) return SEL_A;
    if (b_hit) return SEL_B;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: a load issue marks a register, its port-B writeback clears it.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int PC_IDX   = NUM_REGS - 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mark_en,
  input  logic [AW-1:0]       mark_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  output logic [NUM_REGS-1:0] pending
);

  // A mark beats a same-cycle clear; the PC slot can never become pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r != PC_IDX) begin
          if (mark_en && mark_addr == AW'(r))
            pending[r] <= 1'b1;
          else if (clr_en && clr_addr == AW'(r))
            pending[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD combinational reads, two prioritised writes,
// PC slot with wrap limit, optional write-through bypass and pending scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int          DATA_W   = DEF_DATA_W,
  parameter int          NUM_REGS = DEF_NUM_REGS,
  parameter int          NUM_RD   = 4,
  parameter int          PC_IDX   = NUM_REGS - 1,
  parameter int unsigned PC_LIMIT = DEF_PC_LIMIT,
  parameter int unsigned PC_RESET = DEF_PC_RESET,
  parameter bit          BYPASS   = 1'b1,
  localparam int         AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [DATA_W-1:0]        pc_next,
  output logic [DATA_W-1:0]        pc_out,
  input  logic                     mark_en,
  input  logic [AW-1:0]            mark_addr,
  output logic [NUM_REGS-1:0]      pending
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_base;
  logic [DATA_W-1:0] pc_upd;

  // An explicit PC write overrides the sequential fetch value before the wrap test.
  always_comb begin
    pc_base = pc_next;
    case (write_sel(wa_en && wa_addr == PC_ADDR, wb_en && wb_addr == PC_ADDR))
      SEL_A:   pc_base = wa_data;
      SEL_B:   pc_base = wb_data;
      default: pc_base = pc_next;
    endcase
    pc_upd = (pc_base > DATA_W'(PC_LIMIT)) ? DATA_W'(PC_RESET) : pc_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      pc_q <= DATA_W'(PC_RESET);
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r != PC_IDX) begin
          case (write_sel(wa_en && wa_addr == AW'(r), wb_en && wb_addr == AW'(r)))
            SEL_A:   regs[r] <= wa_data;
            SEL_B:   regs[r] <= wb_data;
            default: ;
          endcase
        end
      end
      pc_q <= pc_upd;
    end
  end

  // The PC slot is never bypassed so decode always sees the architectural PC.
  always_comb begin
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] word;
    wsel_e             sel;
    rd_data = '0;
    ra      = '0;
    word    = '0;
    sel     = SEL_NONE;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*AW +: AW];
      sel = SEL_NONE;
      if (BYPASS)
        sel = write_sel(wa_en && wa_addr == ra, wb_en && wb_addr == ra);
      if (ra == PC_ADDR)
        word = pc_q;
      else if (sel == SEL_A)
        word = wa_data;
      else if (sel == SEL_B)
        word = wb_data;
      else
        word = regs[ra];
      rd_data[i*DATA_W +: DATA_W] = word;
    end
  end

  assign pc_out = pc_q;

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .PC_IDX  (PC_IDX)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .pending  (pending)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (32 regs, 6 read ports) against an array-based model.
module tb_reg_file_mp;

  localparam int DW   = 32;
  localparam int NR   = 32;
  localparam int NRD  = 6;
  localparam int AW   = 5;
  localparam int PCI  = NR - 1;
  localparam int LIM  = 60;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              wa_en, wb_en, mark_en;
  logic [AW-1:0]     wa_addr, wb_addr, mark_addr;
  logic [DW-1:0]     wa_data, wb_data, pc_next, pc_out;
  logic [NR-1:0]     pending;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] mreg [NR];
  logic [DW-1:0] mpc;
  logic [NR-1:0] mpend;

  reg_file_mp #(
    .DATA_W  (DW),
    .NUM_REGS(NR),
    .NUM_RD  (NRD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wa_data  (wa_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .pc_next  (pc_next),
    .pc_out   (pc_out),
    .mark_en  (mark_en),
    .mark_addr(mark_addr),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Reference model: what each register, the PC and the scoreboard must hold.
  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] base;
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) mreg[r] = '0;
      mpc   = '0;
      mpend = '0;
    end else begin
      if (wa_en && wa_addr == PCI)      base = wa_data;
      else if (wb_en && wb_addr == PCI) base = wb_data;
      else                              base = pc_next;
      mpc = (base > LIM) ? '0 : base;
      if (wb_en && wb_addr != PCI) mreg[wb_addr] = wb_data;
      if (wa_en && wa_addr != PCI) mreg[wa_addr] = wa_data;
      if (wb_en) mpend[wb_addr] = 1'b0;
      if (mark_en && mark_addr != PCI) mpend[mark_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == PCI)              return mpc;
    if (wa_en && wa_addr == a) return wa_data;
    if (wb_en && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the state update.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("pc_out", pc_out, mpc);
      checkOutput("pending", pending, mpend);
      for (int i = 0; i < NRD; i++)
        checkOutput($sformatf("rd%0d", i), rd_data[i*DW +: DW], exp_read(rd_addr[i*AW +: AW]));
    end
  end

  task automatic applyStimulus();
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    mark_en = 1'b0; mark_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  initial begin
    logic [AW-1:0] a;
    rst_n   = 1'b0;
    rd_addr = '0;
    pc_next = '0;
    applyStimulus();
    repeat (2) step();
    for (int i = 0; i < NRD; i++) set_rd(i, AW'(i * 3));
    #1;
    for (int i = 0; i < NRD; i++) checkOutput("reset_rd", rd_data[i*DW +: DW], 64'h0);
    checkOutput("reset_pc", pc_out, 64'h0);
    checkOutput("reset_pend", pending, 64'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    pc_next = 32'd8;  step(); checkOutput("pc_8", pc_out, 64'd8);
    pc_next = 32'd60; step(); checkOutput("pc_60", pc_out, 64'd60);
    pc_next = 32'd64; step(); checkOutput("pc_wrap64", pc_out, 64'd0);

    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'hAAAA_0000;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h5555_0000;
    set_rd(0, 5'd3);
    #1 checkOutput("bypass_r3", rd_data[0 +: DW], 64'hAAAA_0000);
    step();
    applyStimulus();
    #1 checkOutput("stored_r3", rd_data[0 +: DW], 64'hAAAA_0000);

    pc_next = 32'h4;
    wb_en = 1'b1; wb_addr = PCI[AW-1:0]; wb_data = 32'h20;
    step(); checkOutput("pc_wb", pc_out, 64'h20);
    applyStimulus();
    wa_en = 1'b1; wa_addr = PCI[AW-1:0]; wa_data = 32'h40;
    step(); checkOutput("pc_wa_wrap", pc_out, 64'h0);
    applyStimulus();

    mark_en = 1'b1; mark_addr = 5'd5;
    step(); checkOutput("mark5", pending[5], 64'h1);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    step(); checkOutput("mark_beats_clr", pending[5], 64'h1);
    mark_en = 1'b0;
    step(); checkOutput("clr5", pending[5], 64'h0);
    applyStimulus();
    mark_en = 1'b1; mark_addr = PCI[AW-1:0];
    step(); checkOutput("mark_pc_ignored", pending, 64'h0);
    applyStimulus();

    pc_next = 32'd12;
    for (int r = 0; r < PCI; r++) begin
      wa_en = 1'b1; wa_addr = AW'(r); wa_data = 32'h1000_0000 + r * 32'h111;
      step();
    end
    applyStimulus();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NRD; i++) begin
        a = AW'($urandom_range(0, NR - 1));
        set_rd(i, a);
        #1;
        checkOutput("wide_read", rd_data[i*DW +: DW],
                    (a == PCI) ? 64'd12 : 64'h1000_0000 + 64'(a) * 64'h111);
      end
      step();
    end

    for (int c = 0; c < 400; c++) begin
      wa_en = 1'($urandom); wa_addr = AW'($urandom); wa_data = $urandom;
      wb_en = 1'($urandom); wb_addr = AW'($urandom); wb_data = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        wa_data = DW'($urandom_range(0, 80));
        wb_data = DW'($urandom_range(0, 80));
      end
      mark_en = 1'($urandom); mark_addr = AW'($urandom);
      pc_next = DW'($urandom_range(0, 80));
      rd_addr = NRD*AW'($urandom);
      if ($urandom_range(0, 3) == 0) set_rd(0, wa_addr);
      if ($urandom_range(0, 3) == 0) set_rd(1, wb_addr);
      step();
    end

    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hDEAD_BEEF;
    mark_en = 1'b1; mark_addr = 5'd9;
    step();
    applyStimulus();
    mark_en = 1'b1; mark_addr = 5'd10;
    set_rd(0, 5'd7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_pc", pc_out, 64'h0);
    checkOutput("async_pend", pending, 64'h0);
    checkOutput("async_r7", rd_data[0 +: DW], 64'h0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      wa_en = 1'($urandom); wa_addr = AW'($urandom); wa_data = $urandom;
      wb_en = 1'($urandom); wb_addr = AW'($urandom); wb_data = $urandom;
      mark_en = 1'($urandom); mark_addr = AW'($urandom);
      pc_next = DW'($urandom_range(0, 80));
      rd_addr = NRD*AW'($urandom);
      step();
    end
    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
